// File: rtl/ifq_pkg.sv
// ifq_pkg: shared constants and entry type for the IF/ID instruction queue
package ifq_pkg;
    localparam int DEPTH_DEF = 4;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction
endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-side and decode-side handshake bundle for the IF/ID queue
interface if_id_queue_if import ifq_pkg::*; #(parameter int DEPTH = DEPTH_DEF);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          InValid;
    logic          InReady;
    logic [31:0]   InstIn;
    logic [31:0]   PCIn;
    logic          Flush;
    logic          OutValid;
    logic          OutReady;
    logic [31:0]   InstOut;
    logic [31:0]   PCOut;
    logic [31:0]   PC4Out;
    logic [CW-1:0] Count;

    modport master (
        output InValid, InstIn, PCIn, Flush, OutReady,
        input  InReady, OutValid, InstOut, PCOut, PC4Out, Count
    );

    modport slave (
        input  InValid, InstIn, PCIn, Flush, OutReady,
        output InReady, OutValid, InstOut, PCOut, PC4Out, Count
    );
endinterface

// File: rtl/ifq_mem.sv
// ifq_mem: DEPTH x 64-bit entry storage, synchronous write, combinational read
module ifq_mem #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [63:0]              i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [63:0]              o_rdata
);
    logic [63:0] r_mem [DEPTH];

    // write the accepted entry; contents are never cleared, validity lives in the count
    always_ff @(posedge Clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: FIFO between fetch and decode with flush, gated NOP outputs and PC+4
module if_id_queue import ifq_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF
) (
    input logic          Clk,
    input logic          Clr,
    if_id_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          w_valid;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    entry_t        w_head;

    ifq_mem #(.DEPTH(DEPTH)) u_mem (
        .Clk     (Clk),
        .i_we    (w_push),
        .i_waddr (r_wp),
        .i_wdata ({q.InstIn, q.PCIn}),
        .i_raddr (r_rp),
        .o_rdata (w_head)
    );

    // handshakes come only from stored state; flush and reset cancel any transfer
    always_comb begin
        w_valid    = r_count != '0;
        w_ready    = r_count < CW'(DEPTH);
        w_push     = q.InValid & w_ready & ~q.Flush & ~Clr;
        w_pop      = w_valid & q.OutReady & ~q.Flush & ~Clr;
        q.InReady  = w_ready;
        q.OutValid = w_valid;
        q.Count    = r_count;
        q.InstOut  = w_valid ? w_head.inst : NOP;
        q.PCOut    = w_valid ? w_head.pc : 32'h0;
        q.PC4Out   = w_valid ? pc_next(w_head.pc) : 32'h0;
    end

    // pointers wrap naturally at the power-of-two depth; flush behaves like reset
    always_ff @(posedge Clk) begin
        if (Clr || q.Flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule
